// File: rtl/pio_loopback_driver_if.sv
// PIO pad bundle: tristate control and output data toward the pad, input data returned from it.
interface pio_loopback_driver_if #(
  parameter int unsigned NUM_IO = 10
);
  logic [NUM_IO-1:0] pad_t;
  logic [NUM_IO-1:0] pad_o;
  logic [NUM_IO-1:0] pad_i;

  modport master (output pad_t, output pad_o, input pad_i);
  modport slave  (input pad_t, input pad_o, output pad_i);
endinterface

// File: rtl/pio_loopback_driver.sv
// Drives a fixed pad pattern sequence through the PIO bank, captures the looped-back
// return through a 2-FF synchronizer and accumulates per-pad mismatch results.
module pio_loopback_driver #(
  parameter int unsigned NUM_IO        = 10,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  pio_loopback_driver_if.master    pads,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [NUM_IO-1:0]        fail_mask,
  output logic [7:0]               err_count,
  output logic [5:0]               pattern_idx
);

  localparam int unsigned IDX_W    = 6;
  localparam int unsigned ERR_W    = 8;
  localparam int unsigned CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned NUM_PAT  = 2 * NUM_IO + 2;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_PAT - 1);
  localparam logic [IDX_W-1:0] WZERO_BASE = IDX_W'(NUM_IO + 2);
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX    = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_RELEASE
  } state_e;

  // Pattern table: zeros, ones, walking one, walking zero.
  function automatic logic [NUM_IO-1:0] pattern_of(input logic [IDX_W-1:0] idx);
    logic [NUM_IO-1:0] p;
    p = '0;
    if (idx == IDX_W'(1)) begin
      p = '1;
    end else if (idx >= IDX_W'(2) && idx < WZERO_BASE) begin
      p = NUM_IO'(1) << (idx - IDX_W'(2));
    end else if (idx >= WZERO_BASE) begin
      p = ~(NUM_IO'(1) << (idx - WZERO_BASE));
    end
    return p;
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_IO-1:0]  pad_t_q, pad_t_d;
  logic [NUM_IO-1:0]  pad_o_q, pad_o_d;
  logic [NUM_IO-1:0]  sync1_q, sync2_q;
  logic [NUM_IO-1:0]  mism;
  logic [NUM_IO-1:0]  fail_mask_d;
  logic [ERR_W-1:0]   err_count_d;
  logic [IDX_W-1:0]   pattern_idx_d;
  logic               busy_d, done_d, pass_d;

  assign pads.pad_t = pad_t_q;
  assign pads.pad_o = pad_o_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pad_t_q     <= '1;
      pad_o_q     <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_mask   <= '0;
      err_count   <= '0;
      pattern_idx <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pad_t_q     <= pad_t_d;
      pad_o_q     <= pad_o_d;
      sync1_q     <= pads.pad_i;
      sync2_q     <= sync1_q;
      busy        <= busy_d;
      done        <= done_d;
      pass        <= pass_d;
      fail_mask   <= fail_mask_d;
      err_count   <= err_count_d;
      pattern_idx <= pattern_idx_d;
    end
  end

  // Next-state and next-output logic; every output is registered from these.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pad_t_d       = pad_t_q;
    pad_o_d       = pad_o_q;
    busy_d        = busy;
    done_d        = 1'b0;
    pass_d        = pass;
    fail_mask_d   = fail_mask;
    err_count_d   = err_count;
    pattern_idx_d = pattern_idx;
    mism          = sync2_q ^ pattern_of(pattern_idx);

    unique case (state_q)
      ST_IDLE: begin
        pad_t_d = '1;
        pad_o_d = '0;
        busy_d  = 1'b0;
        if (start) begin
          fail_mask_d   = '0;
          err_count_d   = '0;
          pass_d        = 1'b0;
          pattern_idx_d = '0;
          pad_t_d       = '0;
          pad_o_d       = pattern_of('0);
          busy_d        = 1'b1;
          cnt_d         = CNT_LOAD;
          state_d       = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        fail_mask_d = fail_mask | mism;
        if (mism != '0 && err_count != ERR_MAX) begin
          err_count_d = err_count + ERR_W'(1);
        end
        if (pattern_idx < LAST_IDX) begin
          pattern_idx_d = pattern_idx + IDX_W'(1);
          pad_o_d       = pattern_of(pattern_idx + IDX_W'(1));
          cnt_d         = CNT_LOAD;
          state_d       = ST_SETTLE;
        end else begin
          pad_t_d = '1;
          pad_o_d = '0;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (fail_mask == '0);
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/pio_loopback_driver.md
Name: pio_loopback_driver

Overview:
- Sequential stimulus/capture stage that sits directly upstream and downstream of the multi-standard bidirectional PIO bank in the IO timing fuzzer designs.
- Drives each pad's tristate control and output data through a fixed pattern sequence.
- Captures the pad input return path through a 2-FF synchronizer and flags per-pad loopback mismatches.
- Gives the fuzzer bitstreams real registered paths on the PIO T/O/I nets and gives silicon bring-up a pass/fail summary.

Parameters:
- NUM_IO, 10, number of pads driven and captured; legal range 1..31.
- SETTLE_CYCLES, 4, cycles each pattern is held before sampling; must be >= 3.

Ports:
- clk  input  1  single clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level-sampled request to run one sequence; acted on only in IDLE.
- pad_t  output  NUM_IO  per-pad tristate control; 1 = high-Z, 0 = drive.
- pad_o  output  NUM_IO  per-pad output data.
- pad_i  input  NUM_IO  per-pad input data returned from the PIO; asynchronous.
- busy  output  1  high while a sequence runs.
- done  output  1  one-cycle pulse at sequence end.
- pass  output  1  high after done if fail_mask == 0; held until next start.
- fail_mask  output  NUM_IO  sticky OR of mismatching bits across all patterns.
- err_count  output  8  number of patterns with any mismatch; saturates at 255.
- pattern_idx  output  6  index of the pattern currently driven.

Behaviour:
- Reset (async, immediate):
  - State IDLE.
  - pad_t all ones (all pads high-Z); pad_o 0.
  - busy, done, pass 0; fail_mask 0; err_count 0; pattern_idx 0.
  - Synchronizer flops cleared.
- Reset mid-sequence aborts the run with identical values. There is no partial result.
- All outputs are registered.
- pad_i passes through two flops (sync1, sync2); comparisons use sync2 only.
- Pattern set, P = 2*NUM_IO+2 patterns (22 at default):
  - idx 0: all zeros.
  - idx 1: all ones.
  - idx 2..NUM_IO+1: walking one, bit idx-2.
  - idx NUM_IO+2..2*NUM_IO+1: walking zero, bit idx-NUM_IO-2.
- States: IDLE, SETTLE, SAMPLE, RELEASE.
- IDLE:
  - pad_t all ones, busy 0.
  - start=1 at edge k: clear fail_mask, err_count and pass; set pattern_idx 0.
  - From cycle k+1: pad_t 0, pad_o = pattern 0, busy 1, settle counter loaded SETTLE_CYCLES-1, enter SETTLE.
- SETTLE:
  - Hold pad_o and decrement the counter.
  - At counter 0, move to SAMPLE.
  - The pattern is held for exactly SETTLE_CYCLES cycles.
- SAMPLE (1 cycle):
  - mism = sync2 XOR pattern; fail_mask |= mism.
  - If mism != 0, increment err_count unless it is 255.
  - If pattern_idx < P-1: increment pattern_idx, drive the new pattern from the next cycle, reload the counter, go to SETTLE.
  - Otherwise go to RELEASE.
- RELEASE (1 cycle):
  - pad_t all ones, pad_o 0, busy still 1.
  - Next cycle: IDLE, busy 0, done 1 for exactly one cycle, pass = (fail_mask == 0).
- Each pattern occupies SETTLE_CYCLES+1 cycles.
  - busy is high for P*(SETTLE_CYCLES+1)+1 cycles.
  - done is at cycle k+1+P*(SETTLE_CYCLES+1)+1, which is k+112 at default.
- start while busy is ignored.
- start held high continuously starts a new run the cycle after done, clearing results.
- Loopback tolerance: pad_i lagging pad_o by d cycles passes iff d <= SETTLE_CYCLES-2.
- pad_t is never 0 outside SETTLE/SAMPLE.
- Arithmetic:
  - err_count is an 8-bit saturating increment.
  - pattern_idx is zero-extended to 6 bits.

Test Plan:
- Ideal loopback (pad_i = pad_o when pad_t=0, else X) with start pulse at cycle 10 -> busy 1 on cycles 11..121, done pulse at cycle 122, pass=1, fail_mask=0x000, err_count=0.
- pad_i[3] stuck at 0, others looped -> fail_mask=0x008, err_count=11 (all-ones, walking-one bit 3, 9 walking-zero patterns other than bit 3), pass=0.
- pad_i[0] and pad_i[1] both forced to pad_o[0]&pad_o[1] (wired-AND short) -> fail_mask=0x003, err_count=4, pass=0.
- rst_n low at cycle 50 mid-run -> same cycle pad_t=0x3FF, busy=0, err_count=0. Fresh start after release runs the full 111-cycle sequence and passes.
- Loopback delayed 2 cycles -> pass=1. Delayed 3 cycles -> pass=0, fail_mask=0x3FF.
- start held high throughout -> second pulse on start during busy has no effect. A new run begins the cycle after done with results cleared. err_count forced through 256 mismatching patterns across a NUM_IO=31 build (all pads stuck at 0, run 6 sequences without clearing via force) -> stays at 255.
